dip_debouncer: RTL and testbench

DIP_DEBOUNCER -- requirements
Module: dip_debouncer

---
 rtl/dip_pkg.sv | 14 +
 rtl/dip_debouncer_if.sv | 29 ++
 rtl/dip_debounce_bit.sv | 60 ++++++
 rtl/dip_debouncer.sv | 71 +++++++
 tb/tb_dip_debouncer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dip_pkg.sv
// Shared constants and helpers for the DIP switch debouncer.
package dip_pkg;

  localparam int DIP_WIDTH            = 8;
  localparam int DIP_DEBOUNCE_DEFAULT = 50000;

  // Width of a per-bit stability counter; it must hold DEBOUNCE_CYCLES-1.
  function automatic int dip_cnt_width(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dip_debouncer_if.sv
// Signal bundle between the DIP switch source and the debouncer.
interface dip_debouncer_if
  import dip_pkg::*;
#(
  parameter int WIDTH = DIP_WIDTH
) ();

  logic [WIDTH-1:0] dip_raw;
  logic [WIDTH-1:0] dip_stable;
  logic             dip_changed;
  logic             dip_valid;

  // Switch side: drives raw levels, observes the debounced result.
  modport master (
    output dip_raw,
    input  dip_stable,
    input  dip_changed,
    input  dip_valid
  );

  // Debouncer side.
  modport slave (
    input  dip_raw,
    output dip_stable,
    output dip_changed,
    output dip_valid
  );

endinterface

// File: rtl/dip_debounce_bit.sv
// One DIP bit: 2-flop synchronizer, stability counter and debounced flop.
module dip_debounce_bit
  import dip_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  input  logic bypass_i,
  output logic stable_o
);

  localparam int              CNT_W    = dip_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous switch level into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatching cycles; any match restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (bypass_i) begin
      stable_d = sync2_q;
    end else if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and debounced level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/dip_debouncer.sv
// DIP switch debouncer: per-bit debounce, initial settle window, change pulse.
module dip_debouncer
  import dip_pkg::*;
#(
  parameter int WIDTH           = DIP_WIDTH,
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dip_raw_i,
  output logic [WIDTH-1:0] dip_stable_o,
  output logic             dip_changed_o,
  output logic             dip_valid_o
);

  // Settle window: long enough for the synchronizer plus one full debounce.
  localparam int               INIT_W    = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(DEBOUNCE_CYCLES + 2);

  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              valid_q, valid_d;
  logic              changed_q, changed_d;
  logic [WIDTH-1:0]  stable_prev_q;
  logic [WIDTH-1:0]  stable_w;
  logic              bypass;

  // Until settled, every bit follows its synchronized input directly.
  assign bypass = ~valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dip_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw_i    (dip_raw_i[i]),
      .bypass_i (bypass),
      .stable_o (stable_w[i])
    );
  end

  // Saturating settle counter, sticky valid, and a single change pulse.
  always_comb begin
    init_cnt_d = init_cnt_q;
    if (init_cnt_q != INIT_DONE) begin
      init_cnt_d = init_cnt_q + INIT_W'(1);
    end
    valid_d   = valid_q | (init_cnt_d == INIT_DONE);
    changed_d = valid_q & (stable_w != stable_prev_q);
  end

  // Control registers; stable_prev_q remembers last cycle's debounced word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt_q    <= '0;
      valid_q       <= 1'b0;
      changed_q     <= 1'b0;
      stable_prev_q <= '0;
    end else begin
      init_cnt_q    <= init_cnt_d;
      valid_q       <= valid_d;
      changed_q     <= changed_d;
      stable_prev_q <= stable_w;
    end
  end

  assign dip_stable_o  = stable_w;
  assign dip_changed_o = changed_q;
  assign dip_valid_o   = valid_q;

endmodule

// File: tb/tb_dip_debouncer.sv
// Self-checking bench for dip_debouncer with DEBOUNCE_CYCLES=4.
module tb_dip_debouncer;

  localparam int W  = 8;
  localparam int DC = 4;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   errors;
  int   checks;

  exp_t       exp_q[$];
  int         pulse_q[$];
  logic [7:0] last_stable;

  dip_debouncer_if #(.WIDTH(W)) dif ();

  dip_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dip_raw_i     (dif.dip_raw),
    .dip_stable_o  (dif.dip_stable),
    .dip_changed_o (dif.dip_changed),
    .dip_valid_o   (dif.dip_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every observed stable change and change pulse pops an expectation.
  initial last_stable = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      last_stable = dif.dip_stable;
    end else begin
      if (dif.dip_stable !== last_stable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stable_change: unexpected change to %h at cyc=%0d", dif.dip_stable, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc !== cyc || e.val !== dif.dip_stable) begin
            errors++;
            $display("FAIL stable_change: got %h at cyc=%0d, expected %h at cyc=%0d",
                     dif.dip_stable, cyc, e.val, e.cyc);
          end
        end
        last_stable = dif.dip_stable;
      end
      if (dif.dip_changed === 1'b1) begin
        checks++;
        if (pulse_q.size() == 0) begin
          errors++;
          $display("FAIL changed_pulse: unexpected pulse at cyc=%0d", cyc);
        end else begin
          int pc;
          pc = pulse_q.pop_front();
          if (pc !== cyc) begin
            errors++;
            $display("FAIL changed_pulse: pulse at cyc=%0d, expected cyc=%0d", cyc, pc);
          end
        end
      end
    end
  end

  task automatic test_reset();
    int r;
    dif.dip_raw = 8'hA5;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dif.dip_stable !== 8'h00) begin
      errors++; $display("FAIL reset_stable: got %h expected 00", dif.dip_stable);
    end
    checks++;
    if (dif.dip_changed !== 1'b0) begin
      errors++; $display("FAIL reset_changed: got %b expected 0", dif.dip_changed);
    end
    checks++;
    if (dif.dip_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", dif.dip_valid);
    end
    r = cyc;
    exp_q.push_back('{cyc: r + 3, val: 8'hA5});
    reset_n = 1'b1;
    for (int i = 1; i <= DC + 2; i++) begin
      @(negedge clk);
      checks++;
      if (dif.dip_valid !== ((i >= DC + 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL init_valid: edge %0d got %b expected %b", i, dif.dip_valid, (i >= DC + 2));
      end
    end
    checks++;
    if (dif.dip_stable !== 8'hA5) begin
      errors++; $display("FAIL init_stable: got %h expected a5", dif.dip_stable);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_step();
    int k;
    k = cyc;
    dif.dip_raw = 8'hA4;
    exp_q.push_back('{cyc: k + DC + 2, val: 8'hA4});
    pulse_q.push_back(k + DC + 3);
    repeat (DC + 1) @(negedge clk);
    checks++;
    if (dif.dip_stable !== 8'hA5) begin
      errors++; $display("FAIL step_early: got %h expected a5", dif.dip_stable);
    end
    @(negedge clk);
    checks++;
    if (dif.dip_stable !== 8'hA4) begin
      errors++; $display("FAIL step_update: got %h expected a4", dif.dip_stable);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pulse_q.size() != 0) begin
      errors++; $display("FAIL step_pulse: %0d pending, expected 0", pulse_q.size());
    end
  endtask

  task automatic test_glitch();
    int k;
    // Short glitch: low for DC-1 sampled cycles must be rejected.
    dif.dip_raw = 8'h24;
    repeat (DC - 1) @(negedge clk);
    dif.dip_raw = 8'hA4;
    repeat (10) @(negedge clk);
    checks++;
    if (dif.dip_stable !== 8'hA4) begin
      errors++; $display("FAIL glitch_short: got %h expected a4", dif.dip_stable);
    end
    // Low for exactly DC cycles: accepted, then the return high is accepted too.
    k = cyc;
    dif.dip_raw = 8'h24;
    exp_q.push_back('{cyc: k + DC + 2, val: 8'h24});
    pulse_q.push_back(k + DC + 3);
    exp_q.push_back('{cyc: k + 2 * DC + 2, val: 8'hA4});
    pulse_q.push_back(k + 2 * DC + 3);
    repeat (DC) @(negedge clk);
    dif.dip_raw = 8'hA4;
    repeat (12) @(negedge clk);
    checks++;
    if (dif.dip_stable !== 8'hA4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_long: got %h pending=%0d expected a4 pending=0", dif.dip_stable, exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    int k;
    k = cyc;
    dif.dip_raw = 8'hED;
    exp_q.push_back('{cyc: k + DC + 2, val: 8'hED});
    pulse_q.push_back(k + DC + 3);
    repeat (10) @(negedge clk);
    checks++;
    if (dif.dip_stable !== 8'hED || pulse_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous: got %h pulses_pending=%0d expected ed 0", dif.dip_stable, pulse_q.size());
    end
  endtask

  task automatic test_bounce();
    int kf;
    logic [7:0] v;
    v = 8'hED;
    for (int t = 0; t <= 20; t++) begin
      v[2] = ~v[2];
      dif.dip_raw = v;
      if (t < 20) repeat (2) @(negedge clk);
    end
    kf = cyc;
    exp_q.push_back('{cyc: kf + DC + 2, val: 8'hE9});
    pulse_q.push_back(kf + DC + 3);
    repeat (12) @(negedge clk);
    checks++;
    if (dif.dip_stable !== 8'hE9 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce: got %h pending=%0d expected e9 pending=0", dif.dip_stable, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    dif.dip_raw = 8'hE8;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dif.dip_stable !== 8'h00) begin
      errors++; $display("FAIL midreset_stable: got %h expected 00", dif.dip_stable);
    end
    checks++;
    if (dif.dip_changed !== 1'b0) begin
      errors++; $display("FAIL midreset_changed: got %b expected 0", dif.dip_changed);
    end
    checks++;
    if (dif.dip_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_valid: got %b expected 0", dif.dip_valid);
    end
    test_reset();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    dif.dip_raw = 8'hA5;
    test_reset();
    test_step();
    test_glitch();
    test_simultaneous();
    test_bounce();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      errors++;
      $display("FAIL final_queues: stable pending=%0d pulse pending=%0d expected 0 0",
               exp_q.size(), pulse_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
